// File: rtl/mips_muldiv_unit.sv
// rtl/mips_muldiv_unit.sv - iterative radix-2 MIPS multiply/divide unit with HI/LO registers
module mips_muldiv_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ITER       = DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  mthi,
    input  logic                  mtlo,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo,
    output logic                  busy,
    output logic                  done
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2*W:0]    acc_q, acc_d;
    logic [W-1:0]    dvs_q, dvs_d;
    logic [1:0]      op_q, op_d;
    logic            neg_q, neg_d;
    logic            rneg_q, rneg_d;
    logic            dz_q, dz_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    hi_q, hi_d;
    logic [W-1:0]    lo_q, lo_d;

    logic            sign_a, sign_b;
    logic [W-1:0]    mag_a, mag_b;
    logic [W:0]      mul_sum;
    logic [2*W:0]    mul_next;
    logic [W:0]      div_shift;
    logic            div_ge;
    logic [W:0]      div_rem;
    logic [2*W:0]    div_next;
    logic [2*W:0]    step_next;
    logic [2*W-1:0]  prod;
    logic [W-1:0]    quot, rem;
    logic [W-1:0]    res_hi, res_lo;

    // Operand magnitudes; odd op codes are the unsigned variants.
    always_comb begin
        sign_a = ~op[0] & a[W-1];
        sign_b = ~op[0] & b[W-1];
        mag_a  = sign_a ? -a : a;
        mag_b  = sign_b ? -b : b;
    end

    // acc holds {upper+carry, multiplier} for multiply and {remainder, quotient} for divide.
    always_comb begin
        mul_sum   = acc_q[2*W:W] + (acc_q[0] ? {1'b0, dvs_q} : {(W+1){1'b0}});
        mul_next  = {1'b0, mul_sum, acc_q[W-1:1]};
        div_shift = {acc_q[2*W-1:W], acc_q[W-1]};
        div_ge    = (div_shift >= {1'b0, dvs_q});
        div_rem   = div_ge ? (div_shift - {1'b0, dvs_q}) : div_shift;
        div_next  = {div_rem, acc_q[W-2:0], div_ge};
        step_next = op_q[1] ? div_next : mul_next;

        prod = neg_q ? -step_next[2*W-1:0] : step_next[2*W-1:0];
        quot = neg_q ? -step_next[W-1:0] : step_next[W-1:0];
        rem  = rneg_q ? -step_next[2*W-1:W] : step_next[2*W-1:W];

        if (!op_q[1]) begin
            res_hi = prod[2*W-1:W];
            res_lo = prod[W-1:0];
        end else if (dz_q) begin
            res_hi = a_q;
            res_lo = {W{1'b1}};
        end else begin
            res_hi = rem;
            res_lo = quot;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        dvs_d   = dvs_q;
        op_d    = op_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        a_d     = a_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_RUN: begin
                acc_d = step_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                    hi_d    = res_hi;
                    lo_d    = res_lo;
                end
            end
            default: begin
                state_d = S_IDLE;
                if (start) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    op_d    = op;
                    neg_d   = sign_a ^ sign_b;
                    rneg_d  = sign_a;
                    dz_d    = (b == '0);
                    a_d     = a;
                    if (op[1]) begin
                        acc_d = {{(W+1){1'b0}}, mag_a};
                        dvs_d = mag_b;
                    end else begin
                        acc_d = {{(W+1){1'b0}}, mag_b};
                        dvs_d = mag_a;
                    end
                end else begin
                    if (mthi) hi_d = wdata;
                    if (mtlo) lo_d = wdata;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            dvs_q   <= '0;
            op_q    <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            a_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            dvs_q   <= dvs_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            a_q     <= a_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
endmodule
